// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave over a 2^WORDS_LOG2 x 32 register array.
// Define AXI_SLAVE_RAND_STALL_EN to throttle handshakes with an LFSR.
module axi_sram_slave #(
    parameter int WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << WORDS_LOG2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [31:0] mem [DEPTH];

    // go=0 holds off the registered readies and beat presentation
    logic go;
`ifdef AXI_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                     lfsr_q[15:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign go = lfsr_d[0];
`else
    assign go = 1'b1;
`endif

    logic unused_sig;
    assign unused_sig = ^{arlen[7:4], arsize, arlock, arcache, arprot,
                          awlen[7:4], awsize, awlock, awcache, awprot};

    // ---------------- read engine ----------------
    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    r_state_t              r_state;
    r_state_t              r_next;
    logic [31:0]           r_addr;
    logic [3:0]            r_len;
    logic [3:0]            r_beat;
    logic [1:0]            r_burst;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rvalid_d;
    logic [31:0]           r_fetch_addr;
    logic                  r_fetch_ok;
    logic [WORDS_LOG2-1:0] r_fetch_idx;

    assign r_fetch_ok  = ~|r_fetch_addr[31:WORDS_LOG2+2];
    assign r_fetch_idx = r_fetch_addr[WORDS_LOG2+1:2];

    always_comb begin
        r_next       = r_state;
        ar_hs        = 1'b0;
        r_hs         = 1'b0;
        r_fetch_addr = r_addr;
        rvalid_d     = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_hs        = arvalid && arready;
                r_fetch_addr = araddr;
                if (ar_hs) r_next = R_BURST;
            end
            R_BURST: begin
                r_hs = rvalid && rready;
                if (r_burst != 2'b00) r_fetch_addr = r_addr + 32'd4;
                if (r_hs && rlast) r_next = R_IDLE;
            end
        endcase
        // a presented beat stays up until it is taken
        if (r_next == R_BURST) rvalid_d = (rvalid && !r_hs) || go;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'd0;
            rresp   <= OKAY;
            rdata   <= 32'd0;
            r_addr  <= 32'd0;
            r_len   <= 4'd0;
            r_beat  <= 4'd0;
            r_burst <= 2'b00;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE) && go;
            rvalid  <= rvalid_d;
            if (ar_hs) begin
                rid     <= arid;
                r_len   <= arlen[3:0];
                r_burst <= arburst;
                r_beat  <= 4'd0;
                rlast   <= (arlen[3:0] == 4'd0);
            end else if (r_hs) begin
                r_beat <= r_beat + 4'd1;
                rlast  <= (r_beat + 4'd1 == r_len);
            end
            if (ar_hs || r_hs) begin
                r_addr <= r_fetch_addr;
                if (r_fetch_ok) begin
                    rdata <= mem[r_fetch_idx];
                    rresp <= OKAY;
                end else begin
                    rdata <= 32'd0;
                    rresp <= SLVERR;
                end
            end
        end
    end

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t              w_state;
    w_state_t              w_next;
    logic [31:0]           w_addr;
    logic [31:0]           w_addr_nx;
    logic [3:0]            w_len;
    logic [3:0]            w_beat;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  beat_err;
    logic                  w_ok;
    logic [WORDS_LOG2-1:0] w_idx;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;

    assign w_ok      = ~|w_addr[31:WORDS_LOG2+2];
    assign w_idx     = w_addr[WORDS_LOG2+1:2];
    assign w_addr_nx = (w_burst == 2'b00) ? w_addr : w_addr + 32'd4;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign b_hs      = bvalid && bready;

    // early wlast, or a beat past len without wlast, both count as errors
    assign beat_err = !w_ok || (wid != bid) ||
                      (wlast ? (w_beat != w_len) : (w_beat == w_len));

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && wlast) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= OKAY;
            w_addr  <= 32'd0;
            w_len   <= 4'd0;
            w_beat  <= 4'd0;
            w_burst <= 2'b00;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE) && go;
            wready  <= (w_next == W_DATA) && go;
            bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                bid     <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen[3:0];
                w_burst <= awburst;
                w_beat  <= 4'd0;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= w_addr_nx;
                w_beat <= w_beat + 4'd1;
                w_err  <= w_err || beat_err;
                if (wlast) bresp <= (w_err || beat_err) ? SLVERR : OKAY;
            end
            if (b_hs) w_err <= 1'b0;
        end
    end

    // storage is never reset; wready drops under reset so no write lands
    always_ff @(posedge clk) begin
        if (w_hs && w_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized scoreboard bench for axi_sram_slave.
// Expected beats/responses are queued at issue and checked by monitors.
module tb_axi_sram_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic [1:0]  arlock = '0;
    logic [3:0]  arcache = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic [1:0]  awlock = '0;
    logic [3:0]  awcache = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 clk = ~clk;

    axi_sram_slave #(.WORDS_LOG2(10)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    rexp_t       re;
    bexp_t       be;
    logic [31:0] model [1024];
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    int          checks = 0;
    int          errors = 0;
    int          r_seen = 0;
    int          b_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return a[31:12] == 20'd0;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a,
                                             input logic [1:0] bu,
                                             input int i);
        if (bu == 2'b00) return a;
        return a + 32'(i) * 32'd4;
    endfunction

    // monitors: pop expectation on each handshake about to complete
    always @(negedge clk) begin
        if (!reset && rvalid && rready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_extra: got beat %h with no expectation",
                         rdata);
            end else begin
                re = rq.pop_front();
                chk("rdata", rdata, re.data);
                chk("rresp", 32'(rresp), 32'(re.resp));
                chk("rid", 32'(rid), 32'(re.id));
                chk("rlast", 32'(rlast), 32'(re.last));
            end
            r_seen++;
        end
        if (!reset && bvalid && bready) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra: got bresp %0d unexpected", bresp);
            end else begin
                be = bq.pop_front();
                chk("bresp", 32'(bresp), 32'(be.resp));
                chk("bid", 32'(bid), 32'(be.id));
            end
            b_seen++;
        end
    end

    task automatic wait_rdy(input int which, input string nm);
        int   c;
        logic r;
        c = 0;
        forever begin
            @(negedge clk);
            r = (which == 0) ? arready : (which == 1) ? awready : wready;
            if (r) break;
            c++;
            if (c > 100) begin
                checks++;
                errors++;
                $display("FAIL %s: ready=0 after 100 cycles, want 1", nm);
                break;
            end
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_arready"}, 32'(arready), 0);
        chk({nm, "_awready"}, 32'(awready), 0);
        chk({nm, "_wready"}, 32'(wready), 0);
        chk({nm, "_rvalid"}, 32'(rvalid), 0);
        chk({nm, "_bvalid"}, 32'(bvalid), 0);
        chk({nm, "_rlast"}, 32'(rlast), 0);
        chk({nm, "_rid"}, 32'(rid), 0);
        chk({nm, "_bid"}, 32'(bid), 0);
        chk({nm, "_rresp"}, 32'(rresp), 0);
        chk({nm, "_bresp"}, 32'(bresp), 0);
        chk({nm, "_rdata"}, rdata, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rel_arready_early", 32'(arready), 0);
        chk("rel_awready_early", 32'(awready), 0);
        @(negedge clk);
        chk("rel_arready", 32'(arready), 1);
        chk("rel_awready", 32'(awready), 1);
        chk("rel_rvalid", 32'(rvalid), 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input bit rnd, input bit stall5);
        int          n;
        int          base;
        int          c;
        bit          stalled;
        logic [31:0] a;
        rexp_t       e;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic        s_last;
        logic [3:0]  s_id;
        n = int'(len[3:0]) + 1;
        for (int i = 0; i < n; i++) begin
            a      = beat_addr(addr, burst, i);
            e.id   = id;
            e.last = (i == n - 1);
            e.data = in_rng(a) ? model[a[11:2]] : 32'd0;
            e.resp = in_rng(a) ? 2'b00 : 2'b10;
            rq.push_back(e);
        end
        base    = r_seen;
        stalled = 0;
        @(posedge clk);
        #1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = 3'($urandom);
        arburst = burst;
        arcache = 4'($urandom);
        arvalid = 1'b1;
        wait_rdy(0, "ar_wait");
        @(posedge clk);
        #1 arvalid = 1'b0;
        c = 0;
        while (r_seen < base + n && c < 400) begin
            c++;
            if (stall5 && !stalled && r_seen == base + 2) begin
                stalled = 1;
                rready  = 1'b0;
                @(negedge clk);
                chk("stall_rvalid", 32'(rvalid), 1);
                s_data = rdata;
                s_resp = rresp;
                s_last = rlast;
                s_id   = rid;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_rvalid_hold", 32'(rvalid), 1);
                    chk("stall_rdata", rdata, s_data);
                    chk("stall_rresp", 32'(rresp), 32'(s_resp));
                    chk("stall_rlast", 32'(rlast), 32'(s_last));
                    chk("stall_rid", 32'(rid), 32'(s_id));
                end
                @(posedge clk);
                #1;
            end else begin
                rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (r_seen < base + n) begin
            checks++;
            errors++;
            $display("FAIL r_timeout: got %0d beats want %0d",
                     r_seen - base, n);
        end else if (!rnd && !stall5) begin
            chk("r_cycles", 32'(c), 32'(n));
        end
        rready = 1'b0;
    endtask

    // beats come from wd/ws; their count may differ from len+1
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input bit bad_wid);
        int          n;
        int          base;
        int          c;
        bit          err;
        logic [31:0] a;
        bexp_t       e;
        n   = wd.size();
        err = bad_wid || (n != int'(len[3:0]) + 1);
        for (int i = 0; i < n; i++) begin
            a = beat_addr(addr, burst, i);
            if (!in_rng(a)) err = 1;
            else begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[i][b]) model[a[11:2]][8*b +: 8] = wd[i][8*b +: 8];
                end
            end
        end
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        base = b_seen;
        @(posedge clk);
        #1;
        awid    = id;
        awaddr  = addr;
        awlen   = len;
        awsize  = 3'($urandom);
        awburst = burst;
        awprot  = 3'($urandom);
        awvalid = 1'b1;
        wait_rdy(1, "aw_wait");
        @(posedge clk);
        #1 awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wid    = bad_wid ? id ^ 4'h1 : id;
            wlast  = (i == n - 1);
            wait_rdy(2, "w_wait");
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        c = 0;
        while (b_seen < base + 1 && c < 200) begin
            c++;
            bready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        if (b_seen < base + 1) begin
            checks++;
            errors++;
            $display("FAIL b_timeout: got no response want 1");
        end
        bready = 1'b0;
    endtask

    task automatic fill(input int n, input bit full_strb);
        wd.delete();
        ws.delete();
        for (int i = 0; i < n; i++) begin
            wd.push_back($urandom);
            ws.push_back(full_strb ? 4'hF : 4'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [7:0]  len;
        int          n;
        int          sel;
        int          bbase;

        repeat (3) @(negedge clk);
        check_reset("por");
        release_reset();

        for (int blk = 0; blk < 64; blk++) begin
            fill(16, 1);
            do_write(4'(blk), 32'(blk * 64), 8'd15, 2'b01, 0);
        end

        wd = '{32'd1, 32'd2, 32'd3, 32'd4};
        ws = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'h5, 32'h100, 8'd3, 2'b01, 0);
        do_read(4'h5, 32'h100, 8'd3, 2'b01, 0, 0);

        wd = '{32'h11223344};
        ws = '{4'hF};
        do_write(4'h2, 32'h40, 8'd0, 2'b01, 0);
        wd = '{32'hAABBCCDD};
        ws = '{4'b0101};
        do_write(4'h2, 32'h40, 8'd0, 2'b01, 0);
        do_read(4'h9, 32'h40, 8'd0, 2'b01, 0, 0);

        do_read(4'hC, 32'h0010_0000, 8'd1, 2'b01, 0, 0);
        do_read(4'h7, 32'h200, 8'd7, 2'b01, 0, 1);
        do_read(4'h3, 32'hFF8, 8'd3, 2'b01, 0, 0);
        do_read(4'h4, 32'hFFFF_FFF8, 8'd3, 2'b10, 0, 0);

        fill(2, 1);
        do_write(4'hA, 32'h300, 8'd3, 2'b01, 0);
        do_read(4'hA, 32'h300, 8'd3, 2'b01, 0, 0);
        fill(4, 1);
        do_write(4'hB, 32'h2C0, 8'd1, 2'b01, 0);
        do_read(4'hB, 32'h2C0, 8'd3, 2'b01, 0, 0);
        fill(3, 0);
        do_write(4'h6, 32'h240, 8'd2, 2'b00, 0);
        do_read(4'h6, 32'h240, 8'd1, 2'b00, 0, 0);
        fill(2, 1);
        do_write(4'h8, 32'h280, 8'd1, 2'b01, 1);
        do_read(4'h8, 32'h280, 8'd1, 2'b01, 0, 0);

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       addr = 32'($urandom_range(0, 4095));
            else if (sel == 7) addr = 32'h1000 - 32'($urandom_range(1, 8)) * 4;
            else if (sel == 8) addr = $urandom;
            else               addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
            len = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                n = int'(len[3:0]) + 1;
                if ($urandom_range(0, 5) == 0)
                    n = $urandom_range(1, int'(len[3:0]) + 3);
                fill(n, $urandom_range(0, 1) == 1);
                do_write(4'($urandom), addr, len, 2'($urandom),
                         $urandom_range(0, 7) == 0);
            end else begin
                do_read(4'($urandom), addr, len, 2'($urandom), 1, 0);
            end
        end

        // reset in the middle of a read burst
        for (int i = 0; i < 16; i++) begin
            re.id   = 4'hD;
            re.data = model[i];
            re.resp = 2'b00;
            re.last = (i == 15);
            rq.push_back(re);
        end
        @(posedge clk);
        #1;
        arid    = 4'hD;
        araddr  = 32'h0;
        arlen   = 8'd15;
        arburst = 2'b01;
        arvalid = 1'b1;
        wait_rdy(0, "ar_wait_rst");
        @(posedge clk);
        #1 arvalid = 1'b0;
        rready = 1'b1;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset("mid_read");
        rq.delete();
        rready = 1'b0;
        release_reset();

        // reset in the middle of a write burst
        bbase = b_seen;
        @(posedge clk);
        #1;
        awid    = 4'h3;
        awaddr  = 32'h380;
        awlen   = 8'd7;
        awburst = 2'b01;
        awvalid = 1'b1;
        wait_rdy(1, "aw_wait_rst");
        @(posedge clk);
        #1 awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1;
            wid    = 4'h3;
            wstrb  = 4'hF;
            wlast  = 1'b0;
            wdata  = $urandom;
            wait_rdy(2, "w_wait_rst");
            model[224 + i] = wdata;
            @(posedge clk);
            #1;
        end
        wdata = $urandom;
        #2 reset = 1'b1;
        #1 check_reset("mid_write");
        repeat (2) @(posedge clk);
        release_reset();
        repeat (2) @(posedge clk);
        #1 wvalid = 1'b0;
        chk("rst_no_bresp", 32'(b_seen), 32'(bbase));
        do_read(4'hE, 32'h380, 8'd7, 2'b01, 0, 0);

        repeat (5) @(posedge clk);
        chk("rq_drained", 32'(rq.size()), 0);
        chk("bq_drained", 32'(bq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 The parameter list SHALL be: WORDS_LOG2, default 10, log2 of the memory depth in 32-bit words.
REQ-002 The ports SHALL be: clk, input, 1, sole clock, rising edge.
REQ-003 The ports SHALL include: reset, input, 1, asynchronous active-high reset.
REQ-004 The ports SHALL include the AR channel: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 The ports SHALL include the R channel: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 The ports SHALL include the AW channel: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-007 The ports SHALL include the W and B channels: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1, bid out 4, bresp out 2, bvalid out 1, bready in 1.

Function
REQ-008 The block SHALL be an AXI3 responder backed by a 2^WORDS_LOG2 x 32 register array, with independent read and write engines.
REQ-009 Word index SHALL be addr[WORDS_LOG2+1:2]; the address is out of range if addr[31:WORDS_LOG2+2] is nonzero.
REQ-010 Burst length SHALL be len[3:0]+1 (1..16); len[7:4] ignored; arsize/awsize, lock, cache and prot ignored (full-word access, strobes select bytes).
REQ-011 burst 00 (FIXED) SHALL hold the address; every other encoding SHALL increment the address by 4 per beat, with 32-bit wrap-around.
REQ-012 Read FSM SHALL have states R_IDLE, R_BURST; arready=1 only in R_IDLE; AR handshake at edge N latches id/addr/len, enters R_BURST, and presents beat 0 with rvalid=1 from edge N+1.
REQ-013 In R_BURST each rvalid&rready edge SHALL advance to the next beat, giving 1 beat/cycle back-to-back; rlast=1 on beat len only; handshake of rlast SHALL return to R_IDLE (arready=1 the next cycle).
REQ-014 rdata, rresp, rid and rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-015 rresp SHALL be OKAY (00) for in-range beats and SLVERR (10) with rdata=0 for out-of-range beats; rid SHALL equal the latched arid.
REQ-016 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-017 Each W handshake SHALL write the bytes enabled by wstrb at the current beat address if in range, otherwise discard; the error flag SHALL be set on any out-of-range beat or wid different from latched awid.
REQ-018 A W handshake with wlast=1 SHALL enter W_RESP; error SHALL also be flagged if the wlast beat count differs from len+1; beats beyond len+1 without wlast SHALL be written with continued address increment and flagged.
REQ-019 In W_RESP: bid=latched awid, bresp=SLVERR if flagged else OKAY; bvalid&bready SHALL return to W_IDLE and clear the flag.
REQ-020 A read beat fetched in the same cycle as a write to the same word SHALL return the pre-write data.
REQ-021 Memory contents SHALL be undefined at power-up and unaffected by reset.

Reset
REQ-022 While reset=1: both FSMs idle, arready=awready=wready=rvalid=bvalid=rlast=0, rid=bid=0, rresp=bresp=0, rdata=0.
REQ-023 arready and awready SHALL be registered and rise at the first clk edge after reset deasserts; reset mid-burst SHALL abort the burst with no response and no further writes.

Configuration
REQ-024 Macro AXI_SLAVE_RAND_STALL_EN SHALL, when defined, gate arready, awready, wready and beat presentation (rvalid) with bit 0 of a 16-bit LFSR (seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle, reset to the seed).
REQ-025 Without AXI_SLAVE_RAND_STALL_EN, no LFSR SHALL exist and the timing SHALL be exactly as in REQ-012 to REQ-019; handshake and data rules SHALL hold in both builds.

Verification
REQ-026 Write awaddr=0x100, awlen=3, INCR, wdata 1..4, wstrb=F -> bresp=OKAY, bid=awid; then read the same burst -> rdata 1,2,3,4 on consecutive cycles, rlast on beat 3.
REQ-027 Write 0xAABBCCDD with wstrb=0101 over 0x11223344 at 0x40 -> read returns 0x11BB33DD.
REQ-028 Read araddr=0x0010_0000 (WORDS_LOG2=10), arlen=1 -> two beats, rresp=SLVERR, rdata=0.
REQ-029 Hold rready=0 for 5 cycles mid-burst -> R outputs stable, no beat lost, order preserved.
REQ-030 Write awlen=3 with wlast on beat 1 -> bresp=SLVERR, beats 0-1 written; also assert reset during R_BURST -> rvalid=0 immediately, arready=1 one edge after release.
